// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: controller states,
// key-length encodings and the round count that each key length implies.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    HOLD  = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEYLEN_128: nr_of = NR_128;
      KEYLEN_192: nr_of = NR_192;
      KEYLEN_256: nr_of = NR_256;
      default:    nr_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round-key index counter: loadable, steps up or down when enabled, saturates
// at limit (up) or zero (down); term flags that the next step lands on the end.
module aes_round_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Encrypt finishes at limit, decrypt at zero.
  assign term = up ? ((cnt + ONE) == limit) : (cnt == ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (up) cnt <= (cnt >= limit) ? cnt : cnt + ONE;
      else    cnt <= (cnt == '0)    ? cnt : cnt - ONE;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for a one-round-per-cycle AES datapath: accepts a block request,
// walks load/round/final strobes with key-ready stalls, and holds the result.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int W      = 128,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_key_len,
  input  logic              in_dir,
  input  logic              key_ready,
  output logic [RIDX_W-1:0] round_idx,
  output logic              core_dir,
  output logic              core_load,
  output logic              core_round,
  output logic              core_final,
  input  logic [W-1:0]      core_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              cfg_err,
  output ctrl_state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side inputs are sampled only on that edge.

  ctrl_state_t       state;
  logic              dir_q;
  logic [RIDX_W-1:0] nr_q;
  logic              accept;
  logic              legal;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_term;
  logic [RIDX_W-1:0] nr_in;

  assign accept = in_valid & in_ready;
  assign legal  = (in_key_len != KEYLEN_BAD);
  assign nr_in  = RIDX_W'(nr_of(in_key_len));

  assign cnt_load = accept & legal;
  assign cnt_en   = key_ready & ((state == LOAD) | (state == ROUND));

  aes_round_cnt #(.WIDTH(RIDX_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (in_dir ? nr_in : '0),
    .en       (cnt_en),
    .up       (~dir_q),
    .limit    (nr_q),
    .cnt      (round_idx),
    .term     (cnt_term)
  );

  // Strobes follow key_ready combinationally so a missing key never fires one.
  assign core_load  = (state == LOAD)  & key_ready;
  assign core_round = (state == ROUND) & key_ready;
  assign core_final = (state == FINAL) & key_ready;
  assign core_dir   = dir_q;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      nr_q      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (!legal) begin
              cfg_err <= 1'b1;
            end else begin
              dir_q    <= in_dir;
              nr_q     <= nr_in;
              in_ready <= 1'b0;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (key_ready) state <= ROUND;
        end
        ROUND: begin
          if (key_ready && cnt_term) state <= FINAL;
        end
        FINAL: begin
          if (key_ready) begin
            out_data  <= core_data;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
